alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_seq_divider.sv | 68 ++++++
 rtl/alu_sequencer.sv | 118 +++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, flag-op range and FSM state encoding for the ALU sequencer.
package alu_seq_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_EQ   = 8;
  localparam int OP_LT   = 9;
  localparam int OP_LTU  = 10;
  localparam int OP_GE   = 11;
  localparam int OP_GEU  = 12;
  localparam int OP_NE   = 13;
  localparam int OP_MUL  = 14;
  localparam int OP_MULH = 15;
  localparam int OP_REM  = 16;
  localparam int OP_DIV  = 17;
  localparam int OP_NOP  = 63;

  localparam int OP_LAST    = OP_DIV;
  localparam int FLAG_OP_LO = OP_EQ;
  localparam int FLAG_OP_HI = OP_NE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic bit is_flag_op(input int op);
    return (op >= FLAG_OP_LO) && (op <= FLAG_OP_HI);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request, shared-ALU and result signals of the sequencer, with sequencer (slave) and environment (master) views.
interface alu_seq_if #(
  parameter int OPW = 6,
  parameter int DW  = 64,
  parameter int TW  = 4
);
  // Both handshakes: a transfer happens on a rising edge where valid & ready are high;
  // valid, once raised, holds with stable payload until that edge; ready never depends on valid.
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic [TW-1:0]  in_tag;

  logic [OPW-1:0] alu_instr;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_c;
  logic           alu_f3;

  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_flag;
  logic           out_err;
  logic [TW-1:0]  out_tag;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, alu_c, alu_f3, out_ready,
    output in_ready, alu_instr, alu_a, alu_b, out_valid, out_data, out_flag, out_err, out_tag
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, alu_c, alu_f3, out_ready,
    input  in_ready, alu_instr, alu_a, alu_b, out_valid, out_data, out_flag, out_err, out_tag
  );

endinterface

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle MSB first; done/quotient present the final step.
module alu_seq_divider #(
  parameter int DW = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW + 1);

  logic          busy_q;
  logic          zero_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] quot_q;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] div_q;

  logic [DW:0]   shifted;
  logic [DW:0]   diff;
  logic [DW-1:0] quot_next;
  logic [DW-1:0] rem_next;

  // A borrow out of the trial subtraction means the divisor did not fit: keep the old remainder.
  always_comb begin
    shifted   = {rem_q, quot_q[DW-1]};
    diff      = shifted - {1'b0, div_q};
    quot_next = {quot_q[DW-2:0], ~diff[DW]};
    rem_next  = diff[DW] ? shifted[DW-1:0] : diff[DW-1:0];
  end

  assign busy     = busy_q;
  assign done     = busy_q & (zero_q | (count_q == CW'(1)));
  assign quotient = zero_q ? '1 : quot_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= 1'b0;
      zero_q  <= 1'b0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
    end else if (start) begin
      busy_q  <= 1'b1;
      zero_q  <= (b == '0);
      count_q <= CW'(DW);
      quot_q  <= a;
      rem_q   <= '0;
      div_q   <= b;
    end else if (busy_q) begin
      if (done) begin
        busy_q  <= 1'b0;
        count_q <= '0;
      end else begin
        quot_q  <= quot_next;
        rem_q   <= rem_next;
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through a shared ALU and holds the result until it is consumed.
// Build option ALU_SEQ_DIV_ITER_EN routes op 17 through the iterative divider instead of the ALU.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPW = 6,
  parameter int DW  = 64,
  parameter int TW  = 4
) (
  input  logic   clock,
  input  logic   reset,
  alu_seq_if.slave bus,
  output state_t dbg_state
);

  localparam logic [OPW-1:0] L_NOP  = OPW'(OP_NOP);
  localparam logic [OPW-1:0] L_LAST = OPW'(OP_LAST);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] instr_q;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic [TW-1:0]  tag_q;
  logic [DW-1:0]  data_q;
  logic           flag_q;
  logic           err_q;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.alu_instr = instr_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.out_data  = data_q;
  assign bus.out_flag  = flag_q;
  assign bus.out_err   = err_q;
  assign bus.out_tag   = tag_q;
  assign dbg_state     = state;

`ifdef ALU_SEQ_DIV_ITER_EN
  localparam logic [OPW-1:0] L_DIV = OPW'(OP_DIV);

  logic          div_busy;
  logic          div_done;
  logic [DW-1:0] div_quotient;

  alu_seq_divider #(.DW(DW)) u_divider (
    .clock    (clock),
    .reset    (reset),
    .start    ((state == IDLE) & bus.in_valid & (bus.in_op == L_DIV)),
    .a        (bus.in_a),
    .b        (bus.in_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      instr_q <= L_NOP;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.in_op;
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            tag_q <= bus.in_tag;
`ifdef ALU_SEQ_DIV_ITER_EN
            if (bus.in_op == L_DIV) begin
              state   <= DIV;
              instr_q <= L_NOP;
            end else
`endif
            begin
              state   <= EXEC;
              // Illegal ops never reach the ALU; they still spend the EXEC cycle.
              instr_q <= (bus.in_op <= L_LAST) ? bus.in_op : L_NOP;
            end
          end
        end
        EXEC: begin
          data_q  <= (op_q <= L_LAST) ? bus.alu_c : '0;
          flag_q  <= is_flag_op(int'(op_q)) ? bus.alu_f3 : 1'b0;
          err_q   <= (op_q > L_LAST);
          instr_q <= L_NOP;
          state   <= HOLD;
        end
`ifdef ALU_SEQ_DIV_ITER_EN
        DIV: begin
          if (div_done) begin
            data_q <= div_quotient;
            flag_q <= 1'b0;
            err_q  <= 1'b0;
            state  <= HOLD;
          end else if (!div_busy) begin
            state  <= IDLE;
          end
        end
`endif
        HOLD: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
